// File: rtl/adder_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder tree.
package adder_tree_pkg;

   // Largest supported operand count.
   localparam int unsigned MAX_NUM_INPUTS = 256;

   // Ceiling log2, evaluated at elaboration.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

   // Width of a level-k partial sum: one carry bit gained per level.
   function automatic int unsigned level_width(input int unsigned adder_width,
                                               input int unsigned k);
      return adder_width + k;
   endfunction

   // True when n is a non-zero power of two.
   function automatic bit is_pow2(input int unsigned n);
      return (n != 0) && ((n & (n - 1)) == 0);
   endfunction

   // Total bits held by level k (entries times entry width).
   function automatic int unsigned level_bits(input int unsigned n,
                                              input int unsigned adder_width,
                                              input int unsigned k);
      return (n >> k) * level_width(adder_width, k);
   endfunction

   // Bit offset of level k inside the flattened all-levels bus.
   function automatic int unsigned level_offset(input int unsigned n,
                                                input int unsigned adder_width,
                                                input int unsigned k);
      int unsigned off;
      off = 0;
      for (int unsigned j = 0; j < k; j++) off += level_bits(n, adder_width, j);
      return off;
   endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered adder level: N_IN/2 pairwise adders feeding a valid-tagged register.
module adder_tree_level
   import adder_tree_pkg::*;
#(
   parameter  int unsigned IN_WIDTH  = 11,
   parameter  int unsigned N_IN      = 8,
   localparam int unsigned OUT_WIDTH = level_width(IN_WIDTH, 1),
   localparam int unsigned N_OUT     = N_IN / 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   input  logic [N_IN*IN_WIDTH-1:0]     i_data,
   input  logic                         i_adv,
   output logic                         o_valid,
   output logic [N_OUT*OUT_WIDTH-1:0]   o_data
);

   logic [N_OUT*OUT_WIDTH-1:0] w_sum;
   logic [N_OUT*OUT_WIDTH-1:0] r_data;
   logic                       r_valid;

   // Pairwise zero-extended sums of entries 2j and 2j+1.
   always_comb begin
      w_sum = '0;
      for (int j = 0; j < int'(N_OUT); j++) begin
         w_sum[j*OUT_WIDTH +: OUT_WIDTH] =
            OUT_WIDTH'(i_data[(2*j)*IN_WIDTH +: IN_WIDTH]) +
            OUT_WIDTH'(i_data[(2*j+1)*IN_WIDTH +: IN_WIDTH]);
      end
   end

   // Stage register: advances with the pipe, data only captured for a valid beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_adv) begin
         r_valid <= i_valid;
         if (i_valid) r_data <= w_sum;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Fully pipelined valid/ready binary adder tree summing NUM_INPUTS unsigned operands per beat.
module pipelined_adder_tree
   import adder_tree_pkg::*;
#(
   parameter  int unsigned ADDER_WIDTH = 11,
   parameter  int unsigned NUM_INPUTS  = 8,
   localparam int unsigned LEVELS      = clog2(NUM_INPUTS),
   localparam int unsigned SUM_WIDTH   = level_width(ADDER_WIDTH, LEVELS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [NUM_INPUTS*ADDER_WIDTH-1:0] in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [SUM_WIDTH-1:0]              out_sum
);

   localparam int unsigned IN_BITS   = NUM_INPUTS * ADDER_WIDTH;
   localparam int unsigned TREE_BITS = level_offset(NUM_INPUTS, ADDER_WIDTH, LEVELS + 1);
   localparam int unsigned SUM_OFF   = level_offset(NUM_INPUTS, ADDER_WIDTH, LEVELS);

   // Reject unsupported parameterisations at elaboration.
   generate
      if (!is_pow2(NUM_INPUTS) || (NUM_INPUTS < 2) || (NUM_INPUTS > MAX_NUM_INPUTS) ||
          (ADDER_WIDTH < 1)) begin : g_bad_params
         $error("pipelined_adder_tree: NUM_INPUTS must be a power of two in 2..256 and ADDER_WIDTH >= 1");
      end
   endgenerate

   // All stage data, level 0 (operands) in the low bits, final sum in the high bits.
   logic [TREE_BITS-1:0] w_tree;
   logic [LEVELS:0]      w_valid;
   logic [LEVELS+1:0]    w_adv;

   logic                 r_s0_valid;
   logic [IN_BITS-1:0]   r_s0_data;

   // Back-to-front advance chain: an empty stage always loads, a full one waits on its successor.
   always_comb begin
      w_adv = '0;
      w_adv[LEVELS+1] = out_ready;
      for (int s = int'(LEVELS); s >= 0; s--) begin
         w_adv[s] = ~w_valid[s] | w_adv[s+1];
      end
   end

   // Stage 0 operand register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s0_valid <= 1'b0;
         r_s0_data  <= '0;
      end else if (w_adv[0]) begin
         r_s0_valid <= in_valid;
         if (in_valid) r_s0_data <= in_data;
      end
   end

   assign w_valid[0]            = r_s0_valid;
   assign w_tree[0 +: IN_BITS]  = r_s0_data;

   // Adder levels 1..LEVELS, each halving the entry count and widening by one bit.
   generate
      for (genvar k = 1; k <= int'(LEVELS); k++) begin : g_level
         localparam int unsigned IN_W    = level_width(ADDER_WIDTH, k - 1);
         localparam int unsigned N_IN    = NUM_INPUTS >> (k - 1);
         localparam int unsigned IN_OFF  = level_offset(NUM_INPUTS, ADDER_WIDTH, k - 1);
         localparam int unsigned OUT_OFF = level_offset(NUM_INPUTS, ADDER_WIDTH, k);
         localparam int unsigned OUT_B   = level_bits(NUM_INPUTS, ADDER_WIDTH, k);

         adder_tree_level #(
            .IN_WIDTH (IN_W),
            .N_IN     (N_IN)
         ) u_level (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_valid[k-1]),
            .i_data  (w_tree[IN_OFF +: N_IN*IN_W]),
            .i_adv   (w_adv[k]),
            .o_valid (w_valid[k]),
            .o_data  (w_tree[OUT_OFF +: OUT_B])
         );
      end
   endgenerate

   assign in_ready  = w_adv[0];
   assign out_valid = w_valid[LEVELS];
   assign out_sum   = w_tree[SUM_OFF +: SUM_WIDTH];

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed and scoreboarded checks of the pipelined adder tree.
module tb_pipelined_adder_tree;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [87:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [13:0] out_sum;

   logic        sm_in_valid, sm_in_ready, sm_out_valid, sm_out_ready;
   logic [1:0]  sm_in_data;
   logic [1:0]  sm_out_sum;

   logic          wd_in_valid, wd_in_ready, wd_out_valid, wd_out_ready;
   logic [2047:0] wd_in_data;
   logic [37:0]   wd_out_sum;

   int checks;
   int errors;
   logic [13:0] sb[$];

   pipelined_adder_tree #(.ADDER_WIDTH(11), .NUM_INPUTS(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
   );

   pipelined_adder_tree #(.ADDER_WIDTH(1), .NUM_INPUTS(2)) u_small (
      .clk(clk), .rst(rst), .in_valid(sm_in_valid), .in_ready(sm_in_ready), .in_data(sm_in_data),
      .out_valid(sm_out_valid), .out_ready(sm_out_ready), .out_sum(sm_out_sum)
   );

   pipelined_adder_tree #(.ADDER_WIDTH(32), .NUM_INPUTS(64)) u_wide (
      .clk(clk), .rst(rst), .in_valid(wd_in_valid), .in_ready(wd_in_ready), .in_data(wd_in_data),
      .out_valid(wd_out_valid), .out_ready(wd_out_ready), .out_sum(wd_out_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference sum of eight 11-bit operands.
   function automatic logic [13:0] ref_sum(input logic [87:0] d);
      logic [13:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) s += 14'(d[i*11 +: 11]);
      return s;
   endfunction

   // Operand vector with operand i = base + stride*i.
   function automatic logic [87:0] mk(input int base, input int stride);
      logic [87:0] d;
      d = '0;
      for (int i = 0; i < 8; i++) d[i*11 +: 11] = 11'(base + stride * i);
      return d;
   endfunction

   // Drive one cycle's inputs at the falling edge and let combinational ready settle.
   task automatic step(input logic v, input logic [87:0] d, input logic r);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_sum !== 14'd0) begin errors++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      rst = 1'b0;
      step(1'b0, '0, 1'b1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_single_beat;
      step(1'b1, {88{1'b1}}, 1'b1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept: got %b expected 1", in_ready); end
      for (int c = 1; c <= 5; c++) begin
         step(1'b0, '0, 1'b1);
         if (c == 4) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: cycle %0d out_valid %b expected 1", c, out_valid); end
            checks++; if (out_sum !== 14'd16376) begin errors++; $display("FAIL single_sum: got %0d expected 16376", out_sum); end
         end else begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_window: cycle %0d out_valid %b expected 0", c, out_valid); end
         end
      end
   endtask

   task automatic test_stream;
      int nres, first, last, bad;
      nres = 0; first = -1; last = -1; bad = 0;
      for (int c = 0; c < 30; c++) begin
         step(c < 20, mk(1, 1), 1'b1);
         if (c < 20) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: cycle %0d got %b expected 1", c, in_ready); end
         end
         if (out_valid === 1'b1) begin
            if (first < 0) first = c;
            last = c;
            nres++;
            checks++; if (out_sum !== 14'd36) begin errors++; $display("FAIL stream_sum: cycle %0d got %0d expected 36", c, out_sum); end
         end
      end
      checks++; if (nres !== 20) begin errors++; $display("FAIL stream_count: got %0d expected 20", nres); end
      checks++; if (first !== 4) begin errors++; $display("FAIL stream_first: got %0d expected 4", first); end
      checks++; if (last !== 23) begin errors++; $display("FAIL stream_contiguous: last %0d expected 23", last); end
   endtask

   task automatic test_backpressure;
      int acc, got;
      logic [13:0] exp;
      acc = 0; got = 0;
      sb.delete();
      for (int c = 0; c < 10; c++) begin
         step(1'b1, mk(acc + 1, 0), 1'b0);
         if (out_valid === 1'b1) begin
            checks++; if (out_sum !== 14'd8) begin errors++; $display("FAIL bp_stable_sum: cycle %0d got %0d expected 8", c, out_sum); end
         end
         if (in_valid && in_ready) begin
            sb.push_back(ref_sum(in_data));
            acc++;
         end
      end
      checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
      for (int c = 0; c < 10; c++) begin
         step(1'b0, '0, 1'b1);
         if (out_valid === 1'b1) begin
            got++;
            exp = (sb.size() > 0) ? sb.pop_front() : 14'h3fff;
            checks++; if (out_sum !== exp) begin errors++; $display("FAIL bp_drain_order: beat %0d got %0d expected %0d", got, out_sum, exp); end
         end
      end
      checks++; if (got !== 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", got); end
   endtask

   task automatic test_random;
      int delivered, cyc, shown;
      logic prev_stall;
      logic [13:0] prev_sum, exp;
      logic [95:0] rnd;
      delivered = 0; cyc = 0; shown = 0; prev_stall = 1'b0; prev_sum = '0;
      sb.delete();
      while (delivered < 10000 && cyc < 50000) begin
         rnd = {$urandom(), $urandom(), $urandom()};
         step(1'($urandom_range(0, 1)), rnd[87:0], 1'($urandom_range(0, 1)));
         cyc++;
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== prev_sum) begin
               errors++;
               if (shown < 10) $display("FAIL rand_stability: cycle %0d valid %b sum %0d expected valid 1 sum %0d", cyc, out_valid, out_sum, prev_sum);
               shown++;
            end
         end
         if (in_valid && in_ready) sb.push_back(ref_sum(in_data));
         if (out_valid && out_ready) begin
            delivered++;
            exp = (sb.size() > 0) ? sb.pop_front() : 14'h3fff;
            checks++;
            if (out_sum !== exp) begin
               errors++;
               if (shown < 10) $display("FAIL rand_scoreboard: beat %0d got %0d expected %0d", delivered, out_sum, exp);
               shown++;
            end
         end
         prev_stall = out_valid & ~out_ready;
         prev_sum   = out_sum;
      end
      checks++; if (delivered !== 10000) begin errors++; $display("FAIL rand_budget: delivered %0d expected 10000", delivered); end
      for (int c = 0; c < 8; c++) begin
         step(1'b0, '0, 1'b1);
         if (out_valid && out_ready) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 14'h3fff;
            checks++; if (out_sum !== exp) begin errors++; $display("FAIL rand_drain: got %0d expected %0d", out_sum, exp); end
         end
      end
      checks++; if (sb.size() !== 0) begin errors++; $display("FAIL rand_leftover: got %0d beats expected 0", sb.size()); end
   endtask

   task automatic test_reset_midstream;
      for (int b = 0; b < 3; b++) begin
         step(1'b1, mk(100 * b, 1), 1'b0);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_accept: beat %0d in_ready %b expected 1", b, in_ready); end
      end
      repeat (3) step(1'b0, '0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_sum !== 14'd28) begin errors++; $display("FAIL mid_head: valid %b sum %0d expected valid 1 sum 28", out_valid, out_sum); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
      checks++; if (out_sum !== 14'd0) begin errors++; $display("FAIL mid_rst_sum: got %0d expected 0", out_sum); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", in_ready); end
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      step(1'b0, '0, 1'b1);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_release: valid %b ready %b expected 0 1", out_valid, in_ready); end
      step(1'b1, mk(0, 200), 1'b1);
      for (int c = 1; c <= 4; c++) begin
         step(1'b0, '0, 1'b1);
         if (c < 4) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard: cycle %0d out_valid %b expected 0", c, out_valid); end
         end else begin
            checks++; if (out_valid !== 1'b1 || out_sum !== 14'd5600) begin errors++; $display("FAIL mid_relatency: valid %b sum %0d expected valid 1 sum 5600", out_valid, out_sum); end
         end
      end
   endtask

   task automatic test_params;
      @(negedge clk);
      sm_in_valid = 1'b1; sm_in_data = 2'b11; sm_out_ready = 1'b1;
      wd_in_valid = 1'b1; wd_in_data = {2048{1'b1}}; wd_out_ready = 1'b1;
      #1;
      checks++; if (sm_in_ready !== 1'b1 || wd_in_ready !== 1'b1) begin errors++; $display("FAIL param_accept: small %b wide %b expected 1 1", sm_in_ready, wd_in_ready); end
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         sm_in_valid = 1'b0; wd_in_valid = 1'b0;
         #1;
         if (c == 2) begin
            checks++; if (sm_out_valid !== 1'b1 || sm_out_sum !== 2'd2) begin errors++; $display("FAIL small_max: valid %b sum %0d expected valid 1 sum 2", sm_out_valid, sm_out_sum); end
         end else begin
            checks++; if (sm_out_valid !== 1'b0) begin errors++; $display("FAIL small_latency: cycle %0d valid %b expected 0", c, sm_out_valid); end
         end
         if (c == 7) begin
            checks++; if (wd_out_valid !== 1'b1 || wd_out_sum !== 38'h3F_FFFF_FFC0) begin errors++; $display("FAIL wide_max: valid %b sum %0h expected valid 1 sum 3fffffffc0", wd_out_valid, wd_out_sum); end
         end else begin
            checks++; if (wd_out_valid !== 1'b0) begin errors++; $display("FAIL wide_latency: cycle %0d valid %b expected 0", c, wd_out_valid); end
         end
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      sm_in_valid = 1'b0; sm_in_data = '0; sm_out_ready = 1'b1;
      wd_in_valid = 1'b0; wd_in_data = '0; wd_out_ready = 1'b1;
      test_reset();
      test_single_beat();
      test_stream();
      test_backpressure();
      test_random();
      test_reset_midstream();
      test_params();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
